otp_frame_serializer: RTL

//  Downstream stage of the OTP encryptor. Accepts each ciphertext byte and its 3-bit pad index,

---
 rtl/otp_frame_serializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/otp_frame_serializer.sv
// otp_frame_serializer: buffers {pad index, ciphertext byte} pairs and sends each as a UART-style frame on tx.
// Optional even-parity bit after the data bits is enabled by defining OTP_SER_PARITY_EN.
module otp_frame_serializer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    input  logic [2:0]                    in_index,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef OTP_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, INDEX, DATA, PARITY, STOP} state_t;
    logic parity;
`else
    typedef enum logic [2:0] {IDLE, START, INDEX, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [10:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [10:0]     sr;
    logic [10:0]     head;
    logic [CCW-1:0]  clk_cnt;
    logic [2:0]      bit_cnt;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            bit_end;

    // Entries are stored {data, index} so the index bits shift out first.
    assign head       = mem[rd_ptr];
    assign full       = count == CW'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign bit_end    = clk_cnt == CCW'(CLKS_PER_BIT - 1);
    assign pop        = !empty && (state == IDLE || (state == STOP && bit_end));
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_data, in_index};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= (push && !pop) ? count + CW'(1) : (!push && pop) ? count - CW'(1) : count;
            if (in_valid && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
`ifdef OTP_SER_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (pop) begin
                sr      <= head;
                tx      <= 1'b0;
                busy    <= 1'b1;
                state   <= START;
                clk_cnt <= '0;
`ifdef OTP_SER_PARITY_EN
                parity  <= ^head;
`endif
            end
        end else if (!bit_end) begin
            clk_cnt <= clk_cnt + CCW'(1);
        end else begin
            clk_cnt <= '0;
            case (state)
                START: begin
                    tx      <= sr[0];
                    sr      <= {1'b0, sr[10:1]};
                    bit_cnt <= '0;
                    state   <= INDEX;
                end
                INDEX: begin
                    tx      <= sr[0];
                    sr      <= {1'b0, sr[10:1]};
                    bit_cnt <= (bit_cnt == 3'd2) ? 3'd0 : bit_cnt + 3'd1;
                    if (bit_cnt == 3'd2) state <= DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
`ifdef OTP_SER_PARITY_EN
                        tx    <= parity;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        tx      <= sr[0];
                        sr      <= {1'b0, sr[10:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
`ifdef OTP_SER_PARITY_EN
                PARITY: begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
`endif
                STOP: begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (pop) begin
                        sr    <= head;
                        tx    <= 1'b0;
                        state <= START;
`ifdef OTP_SER_PARITY_EN
                        parity <= ^head;
`endif
                    end else begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
